// File: rtl/float_pkg.sv
// Shared constants and types for the float32 -> int32 converter.
// Optional feature macro: ROUND_NEAREST_EN (round half-to-even instead of truncating).
package float_pkg;

  localparam int FP32_BIAS = 127;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // Exponent whose unbiased value puts the hidden bit at integer bit 23,
  // i.e. the magnitude register needs no shift at all.
  localparam logic [EXP_W-1:0] EXP_NO_SHIFT = 8'(FP32_BIAS + MANT_W);
  // Smallest exponent that no longer fits a signed 32-bit integer (e = 31).
  localparam logic [EXP_W-1:0] EXP_SAT      = 8'(FP32_BIAS + 31);

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/float32_unpack.sv
// Combinational field split and classification of a float32 operand.
// Optional feature macro: ROUND_NEAREST_EN (lets e = -1 reach the shifter).
module float32_unpack
  import float_pkg::*;
(
  input  logic [31:0] a_operand,
  output fp32_t       fields,
  output logic        is_zero,
  output logic        is_nan,
  output logic        is_inf,
  output logic        too_big,
  output logic        too_small
);

  assign fields  = fp32_t'(a_operand);

  // Zero and denormals both collapse to a zero integer.
  assign is_zero = (fields.exp == '0);
  assign is_nan  = (fields.exp == EXP_SPECIAL) && (fields.mant != '0);
  assign is_inf  = (fields.exp == EXP_SPECIAL) && (fields.mant == '0);

  // e >= 31 cannot be represented (the -2^31 corner is resolved by the top).
  assign too_big = (fields.exp >= EXP_SAT) && (fields.exp != EXP_SPECIAL);

`ifdef ROUND_NEAREST_EN
  // e = -1 may round up to 1, so only e <= -2 is a guaranteed zero.
  assign too_small = !is_zero && (fields.exp < 8'(FP32_BIAS - 1));
`else
  assign too_small = !is_zero && (fields.exp < 8'(FP32_BIAS));
`endif

endmodule

// File: rtl/float32_to_int32_seq.sv
// Multi-cycle float32 -> signed int32 converter with an iterative shifter
// and valid/ready handshakes on both sides. SHIFT_STEP (1, 2, 4 or 8) sets
// how many bit positions the magnitude moves per SHIFT cycle.
// Optional feature macro: ROUND_NEAREST_EN (round half-to-even; default truncates).
module float32_to_int32_seq
  import float_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state, state_n;

  // Operand context captured at accept.
  logic [31:0] mag_q;
  logic        sign_q;
  logic        left_q;
  logic [4:0]  rem_q;
  logic        special_q;
  logic [31:0] spec_res_q;
  logic        spec_exc_q;

  logic [31:0] result_q;
  logic        exc_q;

`ifdef ROUND_NEAREST_EN
  logic        guard_q, sticky_q;
  logic        guard_n, sticky_n;
`endif

  fp32_t       f;
  logic        is_zero, is_nan, is_inf, too_big, too_small;
  logic        is_special;
  logic        left_in;
  logic [4:0]  n_in;
  logic [31:0] spec_res;
  logic        spec_exc;
  logic [4:0]  amt;
  logic [31:0] mag_sh;
  logic [31:0] mag_rnd;
  logic [31:0] final_res;

  float32_unpack u_unpack (
    .a_operand (a_operand),
    .fields    (f),
    .is_zero   (is_zero),
    .is_nan    (is_nan),
    .is_inf    (is_inf),
    .too_big   (too_big),
    .too_small (too_small)
  );

  assign is_special = is_zero | is_nan | is_inf | too_big | too_small;

  // Shift direction and distance relative to the no-shift exponent (e = 23).
  assign left_in = (f.exp > EXP_NO_SHIFT);
  assign n_in    = left_in ? 5'(f.exp - EXP_NO_SHIFT) : 5'(EXP_NO_SHIFT - f.exp);

  // Result for inputs that bypass the shifter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    spec_res = '0;
    spec_exc = 1'b0;
    if (is_nan) begin
      spec_exc = 1'b1;
    end else if (is_inf || too_big) begin
      spec_res = f.sign ? INT32_MIN : INT32_MAX;
      // -2^31 exactly is representable, so it is not flagged.
      spec_exc = !(f.sign && (f.exp == EXP_SAT) && (f.mant == '0));
    end
  end

  assign amt = (rem_q < STEP) ? rem_q : STEP;

  // One SHIFT cycle: move the magnitude by amt positions, one bit at a time,
  // so the bits falling off the right end feed guard/sticky in order.
  always_comb begin
    mag_sh = mag_q;
`ifdef ROUND_NEAREST_EN
    guard_n  = guard_q;
    sticky_n = sticky_q;
`endif
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (5'(i) < amt) begin
        if (left_q) begin
          mag_sh = mag_sh << 1;
        end else begin
`ifdef ROUND_NEAREST_EN
          sticky_n = sticky_n | guard_n;
          guard_n  = mag_sh[0];
`endif
          mag_sh = mag_sh >> 1;
        end
      end
    end
  end

  // Optional rounding, then two's-complement negation for negative inputs.
  always_comb begin
`ifdef ROUND_NEAREST_EN
    mag_rnd = mag_q + {31'b0, guard_q & (sticky_q | mag_q[0])};
`else
    mag_rnd = mag_q;
`endif
    final_res = sign_q ? (~mag_rnd + 32'd1) : mag_rnd;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_n;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = (is_special || (n_in == '0)) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        if (rem_q == amt) state_n = FINISH;
      end
      FINISH: begin
        state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture at accept, iterate in SHIFT, register the result in FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all datapath registers are reset so a mid-operation reset leaves
      // no stale operand context and result reads zero immediately.
      mag_q      <= '0;
      sign_q     <= 1'b0;
      left_q     <= 1'b0;
      rem_q      <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      spec_exc_q <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
`ifdef ROUND_NEAREST_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_q      <= {8'b0, 1'b1, f.mant};
            sign_q     <= f.sign;
            left_q     <= left_in;
            rem_q      <= n_in;
            special_q  <= is_special;
            spec_res_q <= spec_res;
            spec_exc_q <= spec_exc;
`ifdef ROUND_NEAREST_EN
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          mag_q <= mag_sh;
          rem_q <= rem_q - amt;
`ifdef ROUND_NEAREST_EN
          guard_q  <= guard_n;
          sticky_q <= sticky_n;
`endif
        end
        FINISH: begin
          if (special_q) begin
            result_q <= spec_res_q;
            exc_q    <= spec_exc_q;
          end else begin
            result_q <= final_res;
            exc_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign Exception = exc_q;

endmodule

// File: doc/float32_to_int32_seq.md
Name: float32_to_int32_seq

Overview:
- Multi-cycle converter from IEEE-754 float32 to signed int32, the reverse of the integer-domain feed into the float add/sub datapath.
- Iterative barrel-free shifter: trades latency for area.
- Valid/ready handshake on both sides.
- Raises Exception on NaN, Inf and out-of-range inputs, matching the add/sub block's exception semantics.

Parameters:
- SHIFT_STEP, 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  a_operand valid
- in_ready  out  1  block can accept an operand
- a_operand  in  32  float32 input
- out_valid  out  1  result and Exception valid
- out_ready  in  1  consumer accepts result
- result  out  32  signed int32 (two's complement)
- Exception  out  1  invalid or saturated conversion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, Exception=0.
- Reset mid-operation aborts the conversion; the operand is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch sign, exp and {1,mant} into a 32-bit magnitude register.
    - e = exp-127; shift count n = |e-23|.
    - Left shift if e>23, otherwise right shift.
    - Go to SHIFT if n>0 and the input is not special, else go to FINISH.
  - SHIFT: shift the magnitude by min(SHIFT_STEP, remaining) per cycle. Go to FINISH when remaining reaches 0.
  - FINISH: optional rounding, then negate if sign=1; register result and Exception. Go to DONE.
  - DONE: out_valid=1. result and Exception are held stable until out_valid&&out_ready, then go to IDLE.
- in_ready is high only in IDLE; there is no same-cycle re-accept after output handshake. in_valid outside IDLE is ignored.
- Latency from accept to out_valid = ceil(n/SHIFT_STEP)+2 cycles. Special and zero-result cases take 2 cycles.
- Truncation toward zero by default.
- Special cases (SHIFT bypassed):
  - exp=0 (zero/denormal): result 0, Exception 0.
  - e<0: result 0, Exception 0. With the optional feature, e=-1 takes the normal path.
  - exp=255, mant≠0 (NaN): result 0, Exception 1.
  - exp=255, mant=0 (Inf): saturate by sign, Exception 1.
  - e≥31: saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative), Exception 1.
  - Exception: exactly -2^31 (a_operand=0xCF000000) gives 0x80000000 with Exception 0.
- Maximum left shift is 7 (e=30); maximum right shift is 23, or 24 with rounding.

Optional Feature:
- Macro ROUND_NEAREST_EN.
- Defined:
  - Guard and sticky bits are tracked through right shifts.
  - FINISH rounds the magnitude half-to-even before negation.
  - e=-1 is routed through SHIFT with n=24.
  - Latency is unchanged apart from that extra path.
- Undefined: truncation; no guard or sticky logic is synthesised.

Decomposition:
- Package float_pkg:
  - FP32_BIAS=127, EXP_W=8, MANT_W=23
  - EXP_SPECIAL=8'hFF
  - INT32_MAX=32'h7FFFFFFF, INT32_MIN=32'h80000000
  - typedef enum for the states IDLE/SHIFT/FINISH/DONE
  - typedef struct for the unpacked float: sign, exp, mant
- Sub-module float32_unpack (combinational): splits fields and flags is_zero, is_nan, is_inf, too_big, too_small.
- Top level holds the FSM, shifter and handshake.

Test Plan:
- 0x40300000 (2.75), SHIFT_STEP=1 -> 0x00000002, Exception 0, out_valid 24 cycles after accept. With ROUND_NEAREST_EN -> 0x00000003.
- 0xC2F60000 (-123.0) -> 0xFFFFFF85, Exception 0. 0x4E800000 (2^30) -> 0x40000000 after 9 cycles. Repeat with SHIFT_STEP=4: 0x4E800000 after 4 cycles.
- Saturation cases:
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, Exception 1.
  - 0xCF000000 -> 0x80000000, Exception 0.
  - 0xFF800000 (-Inf) -> 0x80000000, Exception 1.
  - 0x7FC00000 (NaN) -> 0x00000000, Exception 1.
- Rounding edges:
  - 0x3F000000 (0.5) -> 0 in both builds.
  - 0x3F400000 (0.75) -> 0, or 1 with macro.
  - 0x3FC00000 (1.5) -> 1, or 2 with macro.
  - 0x40200000 (2.5) -> 2 in both builds.
- Back-pressure: hold out_ready=0 for 5 cycles -> result and Exception stable, in_ready=0, a new in_valid is ignored. After the handshake, in_ready=1 on the next cycle and the next operand converts correctly.
- Drop rst_n mid-SHIFT -> out_valid=0, result=0, in_ready=1 immediately. After release, 0x3F800000 -> 0x00000001.
